// File: rtl/key_event_reader.sv
// key_event_reader: turns the raw active-low board button into clean events.
// A 2-flop synchroniser feeds a debounce/hold FSM. The FSM emits single-cycle
// press, release, long-press and auto-repeat strobes and keeps a press counter.
module key_event_reader #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 100000000,
   parameter int REPEAT_CYCLES   = 20000000
) (
   input  logic       CLK100MHZ,
   input  logic       RST,
   input  logic       KEY_N,
   input  logic       CNT_CLR,
   output logic       key_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic [7:0] press_count
);

   localparam int MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
   localparam int MAX_ALL = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
   localparam int TW = $clog2(MAX_ALL);

   localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
   localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_RELEASED,
      S_PRESS_WAIT,
      S_PRESSED,
      S_REPEAT,
      S_RELEASE_WAIT
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic          long_done;
   logic          key_raw_p0;
   logic          key_sync;

   // Clear takes effect before the increment, so a coincident clear yields 1.
   function automatic logic [7:0] count_inc(input logic [7:0] cnt, input logic clr);
      logic [7:0] base;
      base = clr ? 8'd0 : cnt;
      return base + 8'd1;
   endfunction

   // Two-flop synchroniser for the asynchronous pin; idles at released (1).
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         key_raw_p0 <= 1'b1;
         key_sync   <= 1'b1;
      end else begin
         key_raw_p0 <= KEY_N;
         key_sync   <= key_raw_p0;
      end
   end

   // Debounce / hold FSM with registered strobes and the press counter.
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         state         <= S_RELEASED;
         timer         <= '0;
         long_done     <= 1'b0;
         key_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         press_count   <= 8'd0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         if (CNT_CLR) press_count <= 8'd0;

         case (state)
            S_RELEASED: begin
               timer <= '0;
               if (!key_sync) state <= S_PRESS_WAIT;
            end
            S_PRESS_WAIT: begin
               // Instability is checked first so a late bounce beats the terminal count.
               if (key_sync) begin
                  state <= S_RELEASED;
                  timer <= '0;
               end else if (timer == DEB_LAST) begin
                  state       <= S_PRESSED;
                  timer       <= '0;
                  key_level   <= 1'b1;
                  press_pulse <= 1'b1;
                  press_count <= count_inc(press_count, CNT_CLR);
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_PRESSED: begin
               if (key_sync) begin
                  state <= S_RELEASE_WAIT;
                  timer <= '0;
               end else if (timer == LONG_LAST) begin
                  state      <= S_REPEAT;
                  timer      <= '0;
                  long_pulse <= 1'b1;
                  long_done  <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_REPEAT: begin
               if (key_sync) begin
                  state <= S_RELEASE_WAIT;
                  timer <= '0;
               end else if (timer == REP_LAST) begin
                  timer        <= '0;
                  repeat_pulse <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_RELEASE_WAIT: begin
               // A release glitch returns to the hold state it came from, silently.
               if (!key_sync) begin
                  state <= long_done ? S_REPEAT : S_PRESSED;
                  timer <= '0;
               end else if (timer == DEB_LAST) begin
                  state         <= S_RELEASED;
                  timer         <= '0;
                  key_level     <= 1'b0;
                  release_pulse <= 1'b1;
                  long_done     <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= S_RELEASED;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_event_reader.sv
// Directed bench for key_event_reader with short debounce/long/repeat periods.
module tb_key_event_reader;

   logic       clk;
   logic       rst;
   logic       key_n;
   logic       cnt_clr;
   logic       key_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic [7:0] press_count;

   int checks = 0;
   int errors = 0;
   int n_press = 0;
   int n_rel = 0;
   int n_long = 0;
   int n_rep = 0;
   int n_multi = 0;

   key_event_reader #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES(20),
      .REPEAT_CYCLES(8)
   ) dut (
      .CLK100MHZ(clk),
      .RST(rst),
      .KEY_N(key_n),
      .CNT_CLR(cnt_clr),
      .key_level(key_level),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .long_pulse(long_pulse),
      .repeat_pulse(repeat_pulse),
      .press_count(press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse tallies and overlap detection, sampled mid-cycle.
   always @(negedge clk) begin
      if (press_pulse) n_press++;
      if (release_pulse) n_rel++;
      if (long_pulse) n_long++;
      if (repeat_pulse) n_rep++;
      if ((press_pulse + release_pulse + long_pulse + repeat_pulse) > 1) n_multi++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clean press/release; press strobe at edge 6, release strobe at edge 14.
   task automatic press_release(input logic clr, input logic [7:0] exp_count);
      key_n = 1'b0;
      for (int e = 0; e < 16; e++) begin
         step();
         chk("pr_press", press_pulse, (e == 6));
         chk("pr_release", release_pulse, (e == 14));
         if (e == 6) chk("pr_count", press_count, exp_count);
         if (e == 5) cnt_clr = clr;
         if (e == 6) cnt_clr = 1'b0;
         if (e == 7) key_n = 1'b1;
      end
   endtask

   initial begin
      int p0;
      int r0;
      int l0;
      int q0;
      rst = 1'b1;
      key_n = 1'b1;
      cnt_clr = 1'b0;

      // Reset and idle
      repeat (3) step();
      chk("rst_level", key_level, 0);
      chk("rst_count", press_count, 0);
      chk("rst_pulses", {press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         chk("idle_level", key_level, 0);
      end
      chk("idle_count", press_count, 0);
      chk("idle_pulses", n_press + n_rel + n_long + n_rep, 0);

      // Press, hold through long and repeats, then release
      key_n = 1'b0;
      for (int e = 0; e <= 70; e++) begin
         step();
         chk("hold_press", press_pulse, (e == 6));
         chk("hold_long", long_pulse, (e == 26));
         chk("hold_repeat", repeat_pulse, (e == 34 || e == 42 || e == 50 || e == 58));
         chk("hold_release", release_pulse, (e == 66));
         chk("hold_level", key_level, (e >= 6 && e < 66));
         if (e == 6) chk("hold_count", press_count, 1);
         if (e == 59) key_n = 1'b1;
      end

      // Bounce shorter than the debounce window
      p0 = n_press;
      key_n = 1'b0;
      repeat (3) step();
      key_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("bounce_level", key_level, 0);
      end
      chk("bounce_npress", n_press - p0, 0);
      chk("bounce_count", press_count, 1);

      // Long hold, release, and a 2-cycle glitch inside the release window
      p0 = n_press; r0 = n_rel; l0 = n_long; q0 = n_rep;
      key_n = 1'b0;
      for (int e = 0; e <= 45; e++) begin
         step();
         chk("glitch_press", press_pulse, (e == 6));
         chk("glitch_long", long_pulse, (e == 26));
         chk("glitch_release", release_pulse, (e == 41));
         chk("glitch_level", key_level, (e >= 6 && e < 41));
         if (e == 29) key_n = 1'b1;
         if (e == 32) key_n = 1'b0;
         if (e == 34) key_n = 1'b1;
      end
      chk("glitch_npress", n_press - p0, 1);
      chk("glitch_nrel", n_rel - r0, 1);
      chk("glitch_nlong", n_long - l0, 1);
      chk("glitch_nrep", n_rep - q0, 0);
      chk("glitch_count", press_count, 2);

      // Clear on its own
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_alone", press_count, 0);

      // 256 presses wrap the counter back to 0
      for (int i = 0; i < 256; i++) begin
         press_release(1'b0, 8'((i + 1) % 256));
         chk("wrap_count", press_count, (i + 1) % 256);
      end
      chk("wrap_final", press_count, 0);

      // Clear coincident with an accepted press
      press_release(1'b0, 8'd1);
      press_release(1'b1, 8'd1);
      chk("clr_press_count", press_count, 1);

      // Reset in the middle of PRESS_WAIT with the key still held
      key_n = 1'b0;
      for (int e = 0; e <= 14; e++) begin
         step();
         chk("rstmid_press", press_pulse, (e == 11));
         chk("rstmid_level", key_level, (e >= 11));
         if (e == 4) begin
            chk("rstmid_count0", press_count, 0);
            chk("rstmid_pulses", {release_pulse, long_pulse, repeat_pulse}, 0);
         end
         if (e == 3) rst = 1'b1;
         if (e == 4) rst = 1'b0;
      end
      chk("rstmid_count1", press_count, 1);
      key_n = 1'b1;
      repeat (10) step();

      chk("pulse_overlap", n_multi, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
